// File: rtl/div_pkg.sv
// Shared types and constant helpers for the divider result collector.
// The DIV_ZERO_FLAG_EN macro adds the zero-divisor flag field to the result record.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  // Ceiling log2 usable in parameter and port-width expressions.
  function automatic int div_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  typedef struct packed {
    logic [DIV_WIDTH_DEF-1:0] coc;
    logic [DIV_WIDTH_DEF-1:0] res;
`ifdef DIV_ZERO_FLAG_EN
    logic                     dz;
`endif
  } div_result_t;

endpackage

// File: rtl/div_sync_fifo.sv
// Small synchronous FIFO with registered storage. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is ignored.
module div_sync_fifo
  import div_pkg::*;
#(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           dout,
  output logic [div_clog2(DEPTH):0]  count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = div_clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  T             mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  always_comb begin
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && ((count_q != DEPTH_C) || do_pop_s);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din;
      end
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/div_result_collector.sv
// Collects results of the non-stallable pipelined divider and gates new issues
// so every in-flight result has a guaranteed FIFO slot. Option: DIV_ZERO_FLAG_EN.
module div_result_collector
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH_DEF,
  parameter int DEPTH   = 4,
  parameter int LATENCY = WIDTH + 1
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             div_start,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_coc,
  input  logic [WIDTH-1:0] div_res,
`ifdef DIV_ZERO_FLAG_EN
  input  logic             den_zero,
  output logic             out_dz,
`endif
  output logic             issue_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_coc,
  output logic [WIDTH-1:0] out_res,
  output logic             err_ovf
);

  localparam int AW = div_clog2(DEPTH);
  localparam int IW = div_clog2(LATENCY + DEPTH + 1);
  localparam int SW = IW + 1;
  localparam logic [IW-1:0] INFL_MAX = '1;

  typedef struct packed {
    logic [WIDTH-1:0] coc;
    logic [WIDTH-1:0] res;
`ifdef DIV_ZERO_FLAG_EN
    logic             dz;
`endif
  } result_t;

  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_ovf_q, err_ovf_d;
  logic          spurious_s;
  logic          pop_s;
  logic          drop_s;
  logic          full_s;
  logic          empty_s;
  logic [AW:0]   count_s;
  result_t       din_s;
  result_t       head_s;

`ifdef DIV_ZERO_FLAG_EN
  logic [LATENCY-1:0] dz_sr_q;

  // Zero-divisor flag travels alongside the operation so it meets div_done.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      dz_sr_q <= '0;
    end else begin
      dz_sr_q <= {dz_sr_q[LATENCY-2:0], den_zero};
    end
  end
`endif

  always_comb begin
    din_s     = '0;
    din_s.coc = div_coc;
    din_s.res = div_res;
`ifdef DIV_ZERO_FLAG_EN
    din_s.dz  = dz_sr_q[LATENCY-1];
`endif
  end

  div_sync_fifo #(
    .T     (result_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .push  (div_done),
    .pop   (pop_s),
    .din   (din_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  always_comb begin
    inflight_d = inflight_q;
    spurious_s = 1'b0;
    case ({div_start, div_done})
      2'b10: begin
        if (inflight_q != INFL_MAX) begin
          inflight_d = inflight_q + IW'(1);
        end else begin
          inflight_d = inflight_q;
        end
      end
      2'b01: begin
        // A done with nothing outstanding cannot be matched to an issue.
        if (inflight_q == '0) begin
          inflight_d = '0;
          spurious_s = 1'b1;
        end else begin
          inflight_d = inflight_q - IW'(1);
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    out_valid = !empty_s;
    pop_s     = out_valid && out_ready;
    drop_s    = div_done && full_s && !pop_s;
    issue_ok  = (SW'(inflight_q) + SW'(count_s)) < SW'(DEPTH);
    err_ovf_d = err_ovf_q | drop_s | spurious_s | (div_start & ~issue_ok);
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      inflight_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  assign out_coc = head_s.coc;
  assign out_res = head_s.res;
  assign err_ovf = err_ovf_q;
`ifdef DIV_ZERO_FLAG_EN
  assign out_dz  = head_s.dz;
`endif

endmodule
